// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU-operand and response bundle of the ALU issue controller
interface alu_issue_ctrl_if;
  logic        req0_valid, req0_ready, req0_un;
  logic        req1_valid, req1_ready, req1_un;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0]  req0_s, req1_s;
  logic [31:0] alu_x, alu_y, alu_result;
  logic [3:0]  alu_s;
  logic        alu_un, alu_equal;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_equal, rsp_illegal;
  logic [31:0] rsp_result;
  modport slave (
    input  req0_valid, req0_x, req0_y, req0_s, req0_un,
    input  req1_valid, req1_x, req1_y, req1_s, req1_un,
    output req0_ready, req1_ready,
    output alu_x, alu_y, alu_s, alu_un,
    input  alu_result, alu_equal,
    output rsp_valid, rsp_id, rsp_result, rsp_equal, rsp_illegal,
    input  rsp_ready
  );
  modport master (
    output req0_valid, req0_x, req0_y, req0_s, req0_un,
    output req1_valid, req1_x, req1_y, req1_s, req1_un,
    input  req0_ready, req1_ready,
    input  alu_x, alu_y, alu_s, alu_un,
    output alu_result, alu_equal,
    input  rsp_valid, rsp_id, rsp_result, rsp_equal, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin sharing of one combinational ALU with op-dependent settle time
module alu_issue_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input logic clk,
  input logic rst,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  localparam logic [3:0] MUL_M1 = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_M1 = 4'(DIV_LAT - 1);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, lat_m1, s_sel, alu_s_q, alu_s_d;
  logic [31:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d, res_q, res_d;
  logic last_q, last_d, alu_un_q, alu_un_d, id_q, id_d, vld_q, vld_d, eq_q, eq_d, ill_q, ill_d;
  logic g1, acc, fin, rel, ill;
  always_comb begin
    g1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    acc = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
    s_sel = g1 ? bus.req1_s : bus.req0_s;
    lat_m1 = (s_sel == 4'b0111 || s_sel == 4'b1000) ? MUL_M1 :
             (s_sel == 4'b1001 || s_sel == 4'b1010) ? DIV_M1 : 4'd0;
    fin = (state_q == EXEC) && (cnt_q == 4'd0);
    rel = (state_q == DONE) && bus.rsp_ready;
    ill = alu_s_q[3:2] == 2'b11;
    state_d = acc ? EXEC : fin ? DONE : rel ? IDLE : state_q;
    cnt_d = acc ? lat_m1 : (state_q == EXEC && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    last_d = acc ? g1 : last_q;
    alu_x_d = acc ? (g1 ? bus.req1_x : bus.req0_x) : alu_x_q;
    alu_y_d = acc ? (g1 ? bus.req1_y : bus.req0_y) : alu_y_q;
    alu_s_d = acc ? s_sel : alu_s_q;
    alu_un_d = acc ? (g1 ? bus.req1_un : bus.req0_un) : alu_un_q;
    id_d = acc ? g1 : id_q;
    vld_d = fin ? 1'b1 : rel ? 1'b0 : vld_q;
    res_d = fin ? (ill ? 32'd0 : bus.alu_result) : res_q;
    eq_d = fin ? (~ill & bus.alu_equal) : eq_q;
    ill_d = fin ? ill : ill_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      last_q <= 1'b1;
      alu_x_q <= 32'd0;
      alu_y_q <= 32'd0;
      alu_s_q <= 4'd0;
      alu_un_q <= 1'b0;
      id_q <= 1'b0;
      vld_q <= 1'b0;
      res_q <= 32'd0;
      eq_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      alu_x_q <= alu_x_d;
      alu_y_q <= alu_y_d;
      alu_s_q <= alu_s_d;
      alu_un_q <= alu_un_d;
      id_q <= id_d;
      vld_q <= vld_d;
      res_q <= res_d;
      eq_q <= eq_d;
      ill_q <= ill_d;
    end
  end
  assign bus.req0_ready = acc & ~g1;
  assign bus.req1_ready = acc & g1;
  assign bus.alu_x = alu_x_q;
  assign bus.alu_y = alu_y_q;
  assign bus.alu_s = alu_s_q;
  assign bus.alu_un = alu_un_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_equal = eq_q;
  assign bus.rsp_illegal = ill_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench with a behavioural ALU stub
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl_if b();
  alu_issue_ctrl #(.MUL_LAT(2), .DIV_LAT(8)) dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct packed {logic id; logic [31:0] res; logic eq; logic ill;} exp_t;
  exp_t sb[$];
  function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    case (s)
      4'b0010: return x + y;
      4'b0111: return x * y;
      4'b1000: return 32'(({32'd0, x} * {32'd0, y}) >> 32);
      4'b1001: return (y == 0) ? 32'd0 : x / y;
      4'b1010: return (y == 0) ? 32'd0 : x % y;
      default: return x ^ y;
    endcase
  endfunction
  always_comb begin
    b.alu_result = alu_f(b.alu_s, b.alu_x, b.alu_y);
    b.alu_equal = b.alu_x == b.alu_y;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic g, input int lat, input logic [31:0] res, input logic eq,
                     input logic ill, input int stall);
    logic [31:0] ex, ey;
    exp_t e;
    int n;
    #1;
    chk("req0_ready", 32'(b.req0_ready), 32'(!g));
    chk("req1_ready", 32'(b.req1_ready), 32'(g));
    ex = g ? b.req1_x : b.req0_x;
    ey = g ? b.req1_y : b.req0_y;
    e = '{id: g, res: res, eq: eq, ill: ill};
    sb.push_back(e);
    b.rsp_ready = (stall == 0);
    tick;
    n = 0;
    while (!b.rsp_valid && n < 40) begin
      chk("alu_x_hold", b.alu_x, ex);
      chk("alu_y_hold", b.alu_y, ey);
      tick;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    repeat (stall) begin
      chk("stall_valid", 32'(b.rsp_valid), 32'd1);
      chk("stall_result", b.rsp_result, res);
      chk("stall_ready", 32'(b.req0_ready | b.req1_ready), 32'd0);
      tick;
    end
    b.rsp_ready = 1'b1;
    if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("rsp_id", 32'(b.rsp_id), 32'(e.id));
      chk("rsp_result", b.rsp_result, e.res);
      chk("rsp_equal", 32'(b.rsp_equal), 32'(e.eq));
      chk("rsp_illegal", 32'(b.rsp_illegal), 32'(e.ill));
    end
    tick;
    chk("rsp_valid_clr", 32'(b.rsp_valid), 32'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_alu_x"}, b.alu_x, 32'd0);
    chk({tag, "_alu_y"}, b.alu_y, 32'd0);
    chk({tag, "_alu_s"}, 32'(b.alu_s), 32'd0);
    chk({tag, "_alu_un"}, 32'(b.alu_un), 32'd0);
    chk({tag, "_rsp"}, {27'd0, b.rsp_valid, b.rsp_id, b.rsp_equal, b.rsp_illegal, 1'b0}, 32'd0);
    chk({tag, "_result"}, b.rsp_result, 32'd0);
    chk({tag, "_ready"}, 32'(b.req0_ready | b.req1_ready), 32'd0);
  endtask
  initial begin
    logic seen;
    b.req0_valid = 0; b.req0_x = 0; b.req0_y = 0; b.req0_s = 0; b.req0_un = 0;
    b.req1_valid = 0; b.req1_x = 0; b.req1_y = 0; b.req1_s = 0; b.req1_un = 0;
    b.rsp_ready = 0;
    repeat (2) tick;
    rst = 0;
    chk_zero("reset");
    b.req0_valid = 1; b.req0_s = 4'b0010; b.req0_x = 5; b.req0_y = 7;
    run(0, 1, 12, 0, 0, 0);
    b.req0_x = 1; b.req0_y = 2;
    b.req1_valid = 1; b.req1_s = 4'b0010; b.req1_x = 10; b.req1_y = 10;
    run(1, 1, 20, 1, 0, 0);
    run(0, 1, 3, 0, 0, 0);
    run(1, 1, 20, 1, 0, 0);
    run(0, 1, 3, 0, 0, 0);
    b.req0_valid = 0;
    repeat (3) run(1, 1, 20, 1, 0, 0);
    b.req1_valid = 0;
    b.req0_valid = 1; b.req0_s = 4'b1001; b.req0_x = 100; b.req0_y = 7;
    run(0, 8, 14, 0, 0, 0);
    b.req0_y = 0;
    run(0, 8, 0, 0, 0, 0);
    b.req0_s = 4'b1010; b.req0_y = 7;
    run(0, 8, 2, 0, 0, 0);
    b.req0_s = 4'b0111; b.req0_x = 3; b.req0_y = 4;
    run(0, 2, 12, 0, 0, 0);
    b.req0_s = 4'b1000; b.req0_x = 32'h8000_0000; b.req0_y = 4;
    run(0, 2, 2, 0, 0, 0);
    b.req0_s = 4'b0010; b.req0_x = 9; b.req0_y = 9;
    run(0, 1, 18, 1, 0, 5);
    b.req0_x = 1; b.req0_y = 1;
    run(0, 1, 2, 1, 0, 0);
    b.req0_s = 4'b1001; b.req0_x = 100; b.req0_y = 7;
    #1;
    chk("div_rst_ready", 32'(b.req0_ready), 32'd1);
    tick;
    b.req0_valid = 0;
    repeat (3) tick;
    chk("div_rst_busy", 32'(b.rsp_valid), 32'd0);
    rst = 1;
    tick;
    rst = 0;
    chk_zero("midexec_rst");
    seen = 0;
    repeat (12) begin
      seen |= b.rsp_valid;
      tick;
    end
    chk("dropped_rsp", 32'(seen), 32'd0);
    b.req0_valid = 1; b.req0_s = 4'b0010; b.req0_x = 40; b.req0_y = 2;
    run(0, 1, 42, 0, 0, 0);
    b.req0_valid = 0;
    b.req1_valid = 1; b.req1_s = 4'b1101; b.req1_x = 3; b.req1_y = 3;
    run(1, 1, 0, 0, 1, 0);
    b.req1_s = 4'b0010;
    run(1, 1, 6, 1, 0, 0);
    b.req1_valid = 0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
